// File: rtl/seg7_pkg.sv
// Shared 7-segment encoding, FSM states and conversion constants. Both the
// display encoder and the decoder use these so the two directions agree.
package seg7_pkg;

  // Segment order {a,b,c,d,e,f,g}, bit 6 = a, active-high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  // Number of shift steps: one per bit of the 10-bit accumulator (0..999).
  localparam logic [3:0] CONV_STEPS = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    CONVERT,
    DONE
  } state_t;

  // The three patterns captured at the start-accept edge.
  typedef struct packed {
    logic [6:0] h;
    logic [6:0] t;
    logic [6:0] o;
  } seg_triplet_t;

  // Digit to pattern, used by the display encoder; out-of-range shows a dash.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

  // Reverse double-dabble correction: after a right shift, a BCD nibble
  // that reads 8 or more received a carried-in "16" worth 10, so take 3 off.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] n);
    return (n >= 4'd8) ? 4'(n - 4'd3) : n;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one 7-segment pattern to a BCD digit plus a
// legality flag. A blank pattern is a legal zero only where allow_blank is set.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  input  logic       allow_blank,
  output logic [3:0] digit,
  output logic       valid
);

  // Look up the pattern in the display encoding; anything else is illegal.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    digit = 4'd0;
    valid = 1'b0;
    case (seg)
      SEG_0:     begin digit = 4'd0; valid = 1'b1; end
      SEG_1:     begin digit = 4'd1; valid = 1'b1; end
      SEG_2:     begin digit = 4'd2; valid = 1'b1; end
      SEG_3:     begin digit = 4'd3; valid = 1'b1; end
      SEG_4:     begin digit = 4'd4; valid = 1'b1; end
      SEG_5:     begin digit = 4'd5; valid = 1'b1; end
      SEG_6:     begin digit = 4'd6; valid = 1'b1; end
      SEG_7:     begin digit = 4'd7; valid = 1'b1; end
      SEG_8:     begin digit = 4'd8; valid = 1'b1; end
      SEG_9:     begin digit = 4'd9; valid = 1'b1; end
      SEG_BLANK: begin digit = 4'd0; valid = allow_blank; end
      default:   begin digit = 4'd0; valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/seg7_to_binary.sv
// Three-digit 7-segment to 8-bit binary decoder with start/busy/done
// handshake. Patterns are captured on accept, validated, then converted by
// a 10-step reverse double-dabble on a {bcd[11:0], acc[9:0]} shift register.
module seg7_to_binary
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] seg_h,
  input  logic [6:0] seg_t,
  input  logic [6:0] seg_o,
  output logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic       err_seg,
  output logic       err_range
);

  state_t       state_q, state_d;
  seg_triplet_t cap_q, cap_d;
  logic [3:0]   step_q, step_d;
  logic [21:0]  sr_q, sr_d;
  logic [7:0]   bin_d;
  logic         busy_d, done_d, err_seg_d, err_range_d;

  logic [3:0]   dig_h, dig_t, dig_o;
  logic         ok_h, ok_t, ok_o;
  logic [21:0]  sr_shift, sr_step;
  logic [9:0]   acc;

  // Leading blanks are allowed on hundreds and tens, never on ones.
  seg7_to_bcd u_dec_h (.seg(cap_q.h), .allow_blank(1'b1), .digit(dig_h), .valid(ok_h));
  seg7_to_bcd u_dec_t (.seg(cap_q.t), .allow_blank(1'b1), .digit(dig_t), .valid(ok_t));
  seg7_to_bcd u_dec_o (.seg(cap_q.o), .allow_blank(1'b0), .digit(dig_o), .valid(ok_o));

  // One conversion step: shift everything right, then correct each BCD nibble.
  always_comb begin
    sr_shift = sr_q >> 1;
    sr_step  = {bcd_adjust(sr_shift[21:18]),
                bcd_adjust(sr_shift[17:14]),
                bcd_adjust(sr_shift[13:10]),
                sr_shift[9:0]};
    acc      = sr_q[9:0];
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    step_d      = step_q;
    sr_d        = sr_q;
    bin_d       = bin;
    busy_d      = busy;
    done_d      = done;
    err_seg_d   = err_seg;
    err_range_d = err_range;

    case (state_q)
      IDLE: begin
        if (start) begin
          cap_d   = '{h: seg_h, t: seg_t, o: seg_o};
          busy_d  = 1'b1;
          state_d = DECODE;
        end
      end

      DECODE: begin
        if (!(ok_h && ok_t && ok_o)) begin
          err_seg_d   = 1'b1;
          err_range_d = 1'b0;
          bin_d       = 8'd0;
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          sr_d    = {dig_h, dig_t, dig_o, 10'd0};
          step_d  = 4'd0;
          state_d = CONVERT;
        end
      end

      CONVERT: begin
        if (step_q != CONV_STEPS) begin
          sr_d   = sr_step;
          step_d = step_q + 4'd1;
        end else begin
          if (acc > 10'd255) begin
            err_range_d = 1'b1;
            bin_d       = 8'd0;
          end else begin
            err_range_d = 1'b0;
            bin_d       = acc[7:0];
          end
          err_seg_d = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end

      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cap_q     <= '0;
      step_q    <= 4'd0;
      sr_q      <= '0;
      bin       <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_seg   <= 1'b0;
      err_range <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values of the previous cycle, independent of statement order.
      state_q   <= state_d;
      cap_q     <= cap_d;
      step_q    <= step_d;
      sr_q      <= sr_d;
      bin       <= bin_d;
      busy      <= busy_d;
      done      <= done_d;
      err_seg   <= err_seg_d;
      err_range <= err_range_d;
    end
  end

endmodule

// File: tb/tb_seg7_to_binary.sv
// Self-checking bench: a cycle-level behavioural model (decimal arithmetic
// plus a latency countdown) compared against the DUT on every falling edge,
// with directed scenarios pinning exact values and latencies.
module tb_seg7_to_binary;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] seg_h = '0, seg_t = '0, seg_o = '0;
  logic [7:0] bin;
  logic       busy, done, err_seg, err_range;

  int checks = 0;
  int errors = 0;

  seg7_to_binary dut (
    .clk(clk), .rst(rst), .start(start),
    .seg_h(seg_h), .seg_t(seg_t), .seg_o(seg_o),
    .bin(bin), .busy(busy), .done(done),
    .err_seg(err_seg), .err_range(err_range)
  );

  always #5 clk = ~clk;

  // Digit patterns written out independently of the design package.
  logic [6:0] pat [10];
  localparam logic [6:0] BLANK = 7'b0000000;
  localparam logic [6:0] DASH  = 7'b0000001;

  initial begin
    pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101;
    pat[3] = 7'b1111001; pat[4] = 7'b0110011; pat[5] = 7'b1011011;
    pat[6] = 7'b1011111; pat[7] = 7'b1110000; pat[8] = 7'b1111111;
    pat[9] = 7'b1111011;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern -> digit by table search; blank is zero where allowed.
  function automatic void ref_digit(input logic [6:0] p, input bit allow_blank,
                                    output int d, output bit ok);
    d = 0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++)
      if (p == pat[i]) begin d = i; ok = 1'b1; end
    if (p == BLANK && allow_blank) begin d = 0; ok = 1'b1; end
  endfunction

  // Whole transaction result from decimal arithmetic.
  function automatic void ref_convert(input logic [6:0] h, t, o,
                                      output logic [7:0] b, output bit es, er);
    int dh, dt, dn, v;
    bit kh, kt, kn;
    ref_digit(h, 1'b1, dh, kh);
    ref_digit(t, 1'b1, dt, kt);
    ref_digit(o, 1'b0, dn, kn);
    v = dh * 100 + dt * 10 + dn;
    es = !(kh && kt && kn);
    er = !es && (v > 255);
    b  = (es || er) ? 8'd0 : v[7:0];
  endfunction

  // Behavioural model: accept, count down the latency, present the result.
  bit         m_busy, m_done, m_es, m_er, p_es, p_er;
  logic [7:0] m_bin, p_bin;
  int         m_cnt;
  logic [7:0] s_bin;
  bit         s_es, s_er;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_es <= 0; m_er <= 0; m_bin <= 0; m_cnt <= 0;
    end else if (m_done) begin
      m_done <= 0;
      m_busy <= 0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_done <= 1; m_bin <= p_bin; m_es <= p_es; m_er <= p_er;
      end
      m_cnt <= m_cnt - 1;
    end else if (start) begin
      ref_convert(seg_h, seg_t, seg_o, s_bin, s_es, s_er);
      p_bin  <= s_bin;
      p_es   <= s_es;
      p_er   <= s_er;
      m_busy <= 1;
      m_cnt  <= s_es ? 1 : 12;
    end
  end

  // Compare process: outputs are always meaningful (held between results).
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_busy", busy, m_busy);
      check("cmp_done", done, m_done);
      check("cmp_bin", bin, m_bin);
      check("cmp_err_seg", err_seg, m_es);
      check("cmp_err_range", err_range, m_er);
    end
  end

  // Issue one request from a falling edge and wait (bounded) for done.
  // Leaves the caller on the falling edge where done is seen.
  task automatic go(input logic [6:0] h, t, o, output int lat);
    @(negedge clk);
    seg_h = h; seg_t = t; seg_o = o; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seg_h = 7'($urandom); seg_t = 7'($urandom); seg_o = 7'($urandom);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
    if (!done) check("done_timeout", done, 1);
  endtask

  function automatic logic [6:0] rand_pat();
    int k;
    k = int'($urandom_range(0, 12));
    if (k < 10) return pat[k];
    if (k == 10) return BLANK;
    if (k == 11) return DASH;
    return 7'($urandom);
  endfunction

  int lat, dcount;
  logic [7:0] rb;
  bit res, rer;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_bin", bin, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", {err_seg, err_range}, 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // 255: maximum in range, normal latency, busy drops one cycle after done.
    go(pat[2], pat[5], pat[5], lat);
    check("lat_255", lat, 12);
    check("bin_255", bin, 8'hFF);
    check("err_255", {err_seg, err_range}, 0);
    @(negedge clk);
    check("busy_low_255", busy, 0);

    // Back-to-back, each start in the first IDLE cycle.
    go(BLANK, BLANK, pat[7], lat);
    check("bin_7", bin, 7);
    check("lat_7", lat, 12);
    go(pat[0], pat[0], pat[0], lat);
    check("bin_0", bin, 0);
    go(pat[1], pat[2], pat[8], lat);
    check("bin_128", bin, 8'h80);
    check("lat_128", lat, 12);

    // Range errors.
    go(pat[2], pat[5], pat[6], lat);
    check("lat_256", lat, 12);
    check("err_range_256", err_range, 1);
    check("bin_256", bin, 0);
    go(pat[9], pat[9], pat[9], lat);
    check("err_range_999", err_range, 1);

    // Pattern errors: short latency.
    go(pat[1], DASH, pat[3], lat);
    check("lat_dash", lat, 1);
    check("err_seg_dash", err_seg, 1);
    check("bin_dash", bin, 0);
    go(pat[1], pat[2], BLANK, lat);
    check("err_seg_blank_ones", err_seg, 1);
    check("err_range_blank_ones", err_range, 0);

    // Mixed blanks are legal in either leading position.
    go(pat[1], BLANK, pat[4], lat);
    check("bin_104", bin, 104);
    go(BLANK, pat[4], pat[2], lat);
    check("bin_42", bin, 42);

    // Random transactions against the reference.
    for (int n = 0; n < 60; n++) begin
      logic [6:0] h, t, o;
      h = rand_pat(); t = rand_pat(); o = rand_pat();
      ref_convert(h, t, o, rb, res, rer);
      go(h, t, o, lat);
      check("rand_lat", lat, res ? 1 : 12);
      check("rand_bin", bin, rb);
    end

    // start held high with patterns changing every cycle: accepts at E0 and
    // E14 (and E28), so exactly two dones within the 30-cycle window.
    @(negedge clk);
    seg_h = BLANK; seg_t = pat[$urandom_range(0, 9)]; seg_o = pat[$urandom_range(0, 9)];
    start = 1'b1;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dcount++;
      seg_h = pat[$urandom_range(0, 2)];
      seg_t = pat[$urandom_range(0, 9)];
      seg_o = pat[$urandom_range(0, 9)];
    end
    start = 1'b0;
    check("held_start_dones", dcount, 2);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("held_start_idle", busy, 0);

    // Asynchronous reset in the middle of CONVERT step 5 (edge E6).
    go(pat[1], pat[9], pat[9], lat);
    check("bin_199", bin, 199);
    @(negedge clk);
    seg_h = pat[1]; seg_t = pat[2]; seg_o = pat[3]; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_bin", bin, 0);
    check("abort_done", done, 0);
    check("abort_err", {err_seg, err_range}, 0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    go(pat[1], pat[0], pat[0], lat);
    check("bin_100", bin, 100);
    check("lat_100", lat, 12);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
